ecg_spike_scheduler: RTL and testbench
======================================

// Module: ecg_spike_scheduler
// PURPOSE
//  Sequences an ECG record through the two-neuron spike encoder (positive and inverted channels).
//  Fetches each sample from a sync-read sample RAM and drives i_ecg_pos = s, i_ecg_neg = 0xFFFFF - s.
//  Holds each sample for HOLD_CYC neuron update cycles.
//  Tags neuron spikes with the sample index and buffers them in an event FIFO for a valid/ready consumer.
// PARAMETERS
//  NUM_SAMPLES  3600  samples per run (MIT record length)
//  HOLD_CYC     4     neuron update cycles per sample, >=1
//  FIFO_DEPTH   16    event FIFO entries, power of 2, >=2
//  ADDR_W       12    sample RAM address width
//  DATA_W       20    sample width, signed fixed point
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high
//  start      in   1       begin run; ignored while busy
//  mem_rd_en  out  1       sample RAM read strobe
//  mem_addr   out  ADDR_W  sample RAM address
//  mem_rdata  in   DATA_W  RAM data, valid 1 cycle after mem_rd_en
//  nrn_reset  out  1       1-cycle reset pulse to both neurons
//  i_ecg_pos  out  DATA_W  signed current, positive-channel neuron
//  i_ecg_neg  out  DATA_W  signed current, inverted-channel neuron
//  spike_pos  in   1       positive-channel neuron spike
//  spike_neg  in   1       inverted-channel neuron spike
//  evt_valid  out  1       FIFO not empty
//  evt_ready  in   1       consumer pop
//  evt_data   out  ADDR_W+2  {spike_neg, spike_pos, sample_idx}; FIFO head
//  spike_cnt  out  16      total spikes this run, saturating
//  overflow   out  1       sticky: event dropped on full FIFO
//  busy       out  1       run in progress
//  done       out  1       1-cycle pulse at end of run
// BEHAVIOUR
//  - Reset: state IDLE; idx=0; every output 0; FIFO empty; overflow=0; spike_cnt=0.
//  - FSM states: IDLE, FETCH, LOAD, HOLD, FIN.
//  - IDLE, start=1: nrn_reset=1 for one cycle; clear spike_cnt, overflow, idx; FIFO is NOT flushed; go to FETCH.
//  - FETCH (1 cyc): mem_rd_en=1, mem_addr=idx; currents keep previous values; go to LOAD.
//  - LOAD (1 cyc): register i_ecg_pos=mem_rdata and i_ecg_neg=20'hFFFFF-mem_rdata (mod 2^20); go to HOLD.
//  - HOLD: lasts HOLD_CYC cycles, counted by hcnt. On the last cycle, if idx==NUM_SAMPLES-1 go to FIN; else idx++ and go to FETCH.
//  - FIN (1 cyc): done=1; currents return to 0; go to IDLE.
//  - Throughput: HOLD_CYC+2 cycles per sample.
//  - busy=1 in every state except IDLE. start while busy is ignored.
//  - Spikes are sampled only in HOLD; spikes seen in any other state are ignored.
//  - Spike push: when spike_pos|spike_neg, push {spike_neg, spike_pos, idx}. Simultaneous spikes make ONE entry with both flags set.
//  - spike_cnt adds spike_pos+spike_neg per cycle and saturates at 16'hFFFF.
//  - Pop when evt_valid & evt_ready. evt_data is first-word-fall-through.
//  - Push to a full FIFO: event dropped, overflow=1. Exception: a push and pop in the same cycle on a full FIFO succeeds and nothing is dropped.
//  - Pop on an empty FIFO: no effect.
//  - Reset mid-run: immediate return to reset state. No done pulse, FIFO flushed.
// CONFIGURATION
//  - ECG_SCHED_ABORT_EN defined: adds input port abort (1 bit).
//    - abort=1 in FETCH, LOAD or HOLD: next state is FIN, so done pulses and currents return to 0.
//    - The FIFO is kept. Pushes from the abort cycle are still accepted.
//    - abort in IDLE or FIN is ignored.
//  - ECG_SCHED_ABORT_EN undefined: no abort port; a run always covers all NUM_SAMPLES samples.
// TESTING
//  1. RAM[0..3]={0x00000,0x08000,0x10000,0xFFFFF}, NUM_SAMPLES=4, spikes tied low, pulse start
//     -> i_ecg_neg sequence 0xFFFFF,0xF7FFF,0xEFFFF,0x00000.
//     -> done 4*(HOLD_CYC+2)+1 cycles after start; evt_valid stays 0.
//  2. spike_pos=1 in 2nd HOLD cycle of sample 5; spike_neg=1 in 3rd
//     -> two entries {0,1,5} then {1,0,5}; spike_cnt=2.
//  3. spike_pos=spike_neg=1 together in HOLD of idx 7
//     -> single entry {1,1,7}; spike_cnt=2.
//  4. evt_ready=0, spikes every HOLD cycle
//     -> 16 entries stored, then overflow=1.
//     -> with evt_ready=1 on full + push: no drop, count stays 16.
//  5. reset=1 for one cycle during HOLD of idx 100
//     -> busy=0, outputs 0, FIFO empty, no done.
//     -> then start runs from idx 0.
//  6. (ECG_SCHED_ABORT_EN) abort during FETCH of idx 3
//     -> FIN next cycle, done=1, i_ecg_pos=0 the following cycle, no further mem_rd_en.

Source files
------------

// File: rtl/ecg_spike_scheduler_if.sv
// Spike event stream between the ECG spike scheduler (master) and its consumer (slave).
// evt_data = {spike_neg, spike_pos, sample_idx}; first-word-fall-through FIFO head.
interface ecg_spike_scheduler_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              evt_valid;
  logic              evt_ready;
  logic [ADDR_W+1:0] evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/ecg_spike_scheduler.sv
// Walks an ECG record through the two-neuron spike encoder and queues tagged spike events.
// Optional ECG_SCHED_ABORT_EN adds an abort input that ends the run early through FIN.
module ecg_spike_scheduler #(
  parameter int unsigned NUM_SAMPLES = 3600,
  parameter int unsigned HOLD_CYC    = 4,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
`ifdef ECG_SCHED_ABORT_EN
  input  logic                abort,
`endif
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                nrn_reset,
  output logic [DATA_W-1:0]   i_ecg_pos,
  output logic [DATA_W-1:0]   i_ecg_neg,
  input  logic                spike_pos,
  input  logic                spike_neg,
  ecg_spike_scheduler_if.master evt,
  output logic [15:0]         spike_cnt,
  output logic                overflow,
  output logic                busy,
  output logic                done
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned HCNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [HCNT_W-1:0] LAST_HCNT = HCNT_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    HOLD  = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [HCNT_W-1:0]   hcnt_q;
  logic                mem_rd_en_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                nrn_reset_q;
  logic [DATA_W-1:0]   cur_pos_q;
  logic [DATA_W-1:0]   cur_neg_q;
  logic                busy_q;
  logic                done_q;
  logic [15:0]         spike_cnt_q;
  logic [15:0]         spike_cnt_d;
  logic                overflow_q;

  logic [PTR_W:0]      wr_ptr_q;
  logic [PTR_W:0]      rd_ptr_q;
  logic [ADDR_W+1:0]   fifo_mem_q [FIFO_DEPTH];

  logic                abort_w;
  logic                start_fire;
  logic                in_hold;
  logic                push_req;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic                fifo_full;
  logic [16:0]         cnt_sum;

`ifdef ECG_SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign start_fire = (state_q == IDLE) && start;
  assign in_hold    = (state_q == HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hcnt_q      <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      nrn_reset_q <= 1'b0;
      cur_pos_q   <= '0;
      cur_neg_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      nrn_reset_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= FETCH;
            nrn_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            idx_q       <= '0;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= '0;
          end
        end
        FETCH: begin
          if (abort_w) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (abort_w) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            state_q   <= HOLD;
            hcnt_q    <= '0;
            cur_pos_q <= mem_rdata;
            cur_neg_q <= {DATA_W{1'b1}} - mem_rdata;
          end
        end
        HOLD: begin
          if (abort_w || (hcnt_q == LAST_HCNT && idx_q == LAST_IDX)) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else if (hcnt_q == LAST_HCNT) begin
            // Read strobe and address are issued together with the FETCH state.
            state_q     <= FETCH;
            idx_q       <= idx_q + 1'b1;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= idx_q + 1'b1;
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        FIN: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          cur_pos_q <= '0;
          cur_neg_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push_req   = in_hold && (spike_pos || spike_neg);
  assign pop        = !fifo_empty && evt.evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push       = push_req && (!fifo_full || pop);

  assign cnt_sum     = {1'b0, spike_cnt_q} + 17'(spike_pos) + 17'(spike_neg);
  assign spike_cnt_d = cnt_sum[16] ? '1 : cnt_sum[15:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      spike_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (start_fire) begin
        spike_cnt_q <= '0;
        overflow_q  <= 1'b0;
      end else begin
        if (in_hold) spike_cnt_q <= spike_cnt_d;
        if (push_req && !push) overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {spike_neg, spike_pos, idx_q};
  end

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_data  = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign nrn_reset = nrn_reset_q;
  assign i_ecg_pos = cur_pos_q;
  assign i_ecg_neg = cur_neg_q;
  assign spike_cnt = spike_cnt_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ecg_spike_scheduler.sv
// Directed bench for ecg_spike_scheduler: 128-sample record, HOLD_CYC=4 (6 cycles per sample).
// Time t counts cycles after the start edge: sample k FETCH at 6k, LOAD 6k+1, HOLD 6k+2..6k+5.
module tb_ecg_spike_scheduler;

  localparam int unsigned NS     = 128;
  localparam int unsigned HC     = 4;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              nrn_reset;
  logic [DATA_W-1:0] i_ecg_pos;
  logic [DATA_W-1:0] i_ecg_neg;
  logic              spike_pos;
  logic              spike_neg;
  logic [15:0]       spike_cnt;
  logic              overflow;
  logic              busy;
  logic              done;
`ifdef ECG_SCHED_ABORT_EN
  logic              abort;
`endif

  ecg_spike_scheduler_if #(.ADDR_W(ADDR_W)) evt_if ();

  ecg_spike_scheduler #(
    .NUM_SAMPLES(NS),
    .HOLD_CYC   (HC),
    .FIFO_DEPTH (16),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef ECG_SCHED_ABORT_EN
    .abort     (abort),
`endif
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .nrn_reset (nrn_reset),
    .i_ecg_pos (i_ecg_pos),
    .i_ecg_neg (i_ecg_neg),
    .spike_pos (spike_pos),
    .spike_neg (spike_neg),
    .evt       (evt_if.master),
    .spike_cnt (spike_cnt),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram [0:4095];
  initial mem_rdata = '0;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  int n_err    = 0;
  int n_checks = 0;
  int t        = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic go_to(input int target);
    while (t < target) tick();
  endtask

  task automatic start_run();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W+1:0] exp_data;
    int                exp_idx;
    bit                bad;

    for (int i = 0; i < 4096; i++) ram[i] = 20'((i * 7919 + 333) & 'hFFFFF);
    ram[0] = 20'h00000;
    ram[1] = 20'h08000;
    ram[2] = 20'h10000;
    ram[3] = 20'hFFFFF;

    reset = 1'b1; start = 1'b0; spike_pos = 1'b0; spike_neg = 1'b0;
    evt_if.evt_ready = 1'b0;
`ifdef ECG_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    check("rst_nrn_reset", 32'(nrn_reset), 0);
    check("rst_pos", 32'(i_ecg_pos), 0);
    check("rst_neg", 32'(i_ecg_neg), 0);
    check("rst_evt_valid", 32'(evt_if.evt_valid), 0);
    check("rst_spike_cnt", 32'(spike_cnt), 0);
    check("rst_overflow", 32'(overflow), 0);

    // Run 1: current sequence, spike tagging, FIFO fill/overflow
    start_run();
    check("r1_nrn_reset", 32'(nrn_reset), 1);
    check("r1_rd_en", 32'(mem_rd_en), 1);
    check("r1_addr0", 32'(mem_addr), 0);
    check("r1_busy", 32'(busy), 1);
    tick();
    check("r1_nrn_reset_pulse", 32'(nrn_reset), 0);
    go_to(2);
    check("r1_neg0", 32'(i_ecg_neg), 32'h000FFFFF);
    check("r1_pos0", 32'(i_ecg_pos), 32'h00000000);
    go_to(8);
    check("r1_neg1", 32'(i_ecg_neg), 32'h000F7FFF);
    check("r1_pos1", 32'(i_ecg_pos), 32'h00008000);
    go_to(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("r1_start_ignored", 32'(nrn_reset), 0);
    go_to(12);
    check("r1_addr2", 32'(mem_addr), 2);
    check("r1_rd_en2", 32'(mem_rd_en), 1);
    go_to(14);
    check("r1_neg2", 32'(i_ecg_neg), 32'h000EFFFF);
    go_to(20);
    check("r1_neg3", 32'(i_ecg_neg), 32'h00000000);
    check("r1_pos3", 32'(i_ecg_pos), 32'h000FFFFF);
    go_to(30);
    check("r1_no_evt", 32'(evt_if.evt_valid), 0);

    go_to(33); spike_pos = 1'b1;
    tick();    spike_pos = 1'b0; spike_neg = 1'b1;
    tick();    spike_neg = 1'b0;
    check("t2_spike_cnt", 32'(spike_cnt), 2);
    check("t2_valid", 32'(evt_if.evt_valid), 1);
    check("t2_head", 32'(evt_if.evt_data), 32'h1005);

    go_to(44); spike_pos = 1'b1; spike_neg = 1'b1;
    tick();    spike_pos = 1'b0; spike_neg = 1'b0;
    check("t3_spike_cnt", 32'(spike_cnt), 4);

    go_to(50);
    check("t2_pop0", 32'(evt_if.evt_data), 32'h1005);
    evt_if.evt_ready = 1'b1;
    tick();
    check("t2_pop1", 32'(evt_if.evt_data), 32'h2005);
    tick();
    check("t3_pop", 32'(evt_if.evt_data), 32'h3007);
    tick();
    check("t3_drained", 32'(evt_if.evt_valid), 0);
    evt_if.evt_ready = 1'b0;

    go_to(60); spike_pos = 1'b1;
    go_to(84);
    check("t4_full_valid", 32'(evt_if.evt_valid), 1);
    check("t4_no_ovf_yet", 32'(overflow), 0);
    go_to(86);
    check("t4_head", 32'(evt_if.evt_data), 32'h100A);
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    check("t4_push_pop_full", 32'(overflow), 0);
    tick();
    spike_pos = 1'b0;
    check("t4_overflow", 32'(overflow), 1);
    check("t4_spike_cnt", 32'(spike_cnt), 22);
    evt_if.evt_ready = 1'b1;
    bad = 1'b0;
    for (int j = 0; j < 16; j++) begin
      exp_idx  = (j < 3) ? 10 : (j < 7) ? 11 : (j < 11) ? 12 : (j < 15) ? 13 : 14;
      exp_data = {2'b01, 12'(exp_idx)};
      if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== exp_data) begin
        bad = 1'b1;
        $display("FAIL t4_entry%0d: observed valid=%0b data=%0h expected valid=1 data=%0h",
                 j, evt_if.evt_valid, evt_if.evt_data, exp_data);
      end
      tick();
    end
    check("t4_16_entries", 32'(bad), 0);
    check("t4_empty_after_16", 32'(evt_if.evt_valid), 0);
    evt_if.evt_ready = 1'b0;

    go_to(6 * NS - 1);
    check("r1_done_early", 32'(done), 0);
    tick();
    check("r1_done", 32'(done), 1);
    check("r1_fin_busy", 32'(busy), 1);
    check("r1_fin_pos", 32'(i_ecg_pos), 32'(ram[NS-1]));
    tick();
    check("r1_done_pulse", 32'(done), 0);
    check("r1_idle_busy", 32'(busy), 0);
    check("r1_idle_pos", 32'(i_ecg_pos), 0);
    check("r1_idle_neg", 32'(i_ecg_neg), 0);
    check("r1_ovf_sticky", 32'(overflow), 1);
    check("r1_cnt_hold", 32'(spike_cnt), 22);

    // Run 2: reset during HOLD of idx 100
    start_run();
    check("r2_ovf_clear", 32'(overflow), 0);
    check("r2_cnt_clear", 32'(spike_cnt), 0);
    go_to(2); spike_pos = 1'b1;
    tick();   spike_pos = 1'b0;
    check("r2_evt", 32'(evt_if.evt_data), 32'h1000);
    go_to(600);
    check("r2_addr100", 32'(mem_addr), 100);
    go_to(602);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_busy", 32'(busy), 0);
    check("t5_pos", 32'(i_ecg_pos), 0);
    check("t5_neg", 32'(i_ecg_neg), 0);
    check("t5_flushed", 32'(evt_if.evt_valid), 0);
    check("t5_cnt", 32'(spike_cnt), 0);
    check("t5_rd_en", 32'(mem_rd_en), 0);
    bad = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      tick();
    end
    check("t5_no_done", 32'(bad), 0);

    // Run 3: restart from idx 0 and bounded wait for done
    start_run();
    check("t5_restart_addr", 32'(mem_addr), 0);
    check("t5_restart_nrn", 32'(nrn_reset), 1);
    go_to(8);
    check("t5_restart_pos1", 32'(i_ecg_pos), 32'h00008000);
    while (done !== 1'b1 && t < 1000) tick();
    check("t5_done_seen", 32'(done), 1);
    check("t5_done_time", 32'(t), 6 * NS);
    tick();

`ifdef ECG_SCHED_ABORT_EN
    // Run 4: abort during FETCH of idx 3
    start_run();
    go_to(18);
    check("t6_fetch3", 32'(mem_addr), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_done", 32'(done), 1);
    check("t6_rd_en", 32'(mem_rd_en), 0);
    check("t6_fin_pos", 32'(i_ecg_pos), 32'h00010000);
    tick();
    check("t6_pos_zero", 32'(i_ecg_pos), 0);
    check("t6_idle", 32'(busy), 0);
    bad = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (mem_rd_en !== 1'b0 || done !== 1'b0) bad = 1'b1;
      tick();
    end
    check("t6_quiet", 32'(bad), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
